// File: rtl/lm_sm_pkg.sv
// rtl/lm_sm_pkg.sv - shared types and constants for the LM/SM multi-register sequencer
package lm_sm_pkg;

  localparam int NREGS = 8;
  localparam int IDX_W = 3;

  localparam logic [3:0] OP_LM = 4'd6;
  localparam logic [3:0] OP_SM = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WB,
    DONE
  } state_t;

endpackage

// File: rtl/lsb_prio_enc8.sv
// rtl/lsb_prio_enc8.sv - combinational lowest-set-bit encoder for an 8-bit vector
module lsb_prio_enc8
  import lm_sm_pkg::*;
(
  input  logic [NREGS-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the last hit written is the lowest set bit.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - walks an LM/SM register mask, one memory transfer per set bit
module lm_sm_sequencer
  import lm_sm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rf_rd_idx,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_idx,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        xfer_count
);

  state_t             state, state_nxt;
  logic [NREGS-1:0]   pend_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic               store_q;
  logic [IDX_W-1:0]   cur_idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [3:0]         xfer_q;

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               step;

  lsb_prio_enc8 u_enc (
    .vec (pend_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // One transfer retires either on a store ack or in the load writeback cycle.
  assign step = ((state == REQ) && mem_ack && store_q) || (state == WB);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: state_nxt = enc_any ? REQ : DONE;
      REQ:  if (mem_ack) state_nxt = store_q ? SCAN : WB;
      WB:   state_nxt = SCAN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state     <= IDLE;
      pend_q    <= '0;
      ptr_q     <= '0;
      store_q   <= 1'b0;
      cur_idx_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      xfer_q    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        pend_q  <= reg_mask;
        ptr_q   <= base_addr;
        store_q <= is_store;
        xfer_q  <= '0;
      end
      // rf_rd_idx follows the encoder in SCAN, so rf_rd_data is already the source word.
      if ((state == SCAN) && enc_any) begin
        cur_idx_q <= enc_idx;
        wdata_q   <= rf_rd_data;
      end
      if ((state == REQ) && mem_ack && !store_q) rdata_q <= mem_rdata;
      if (step) begin
        pend_q <= pend_q & ~(NREGS'(1) << cur_idx_q);
        ptr_q  <= ptr_q + ADDR_W'(1);
        xfer_q <= xfer_q + 4'd1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign rf_rd_idx  = (state == SCAN) ? enc_idx : cur_idx_q;
  assign rf_wr_en   = (state == WB);
  assign rf_wr_idx  = cur_idx_q;
  assign rf_wr_data = rdata_q;
  assign mem_req    = (state == REQ);
  assign mem_we     = (state == REQ) && store_q;
  assign mem_addr   = ptr_q;
  assign mem_wdata  = wdata_q;
  assign xfer_count = xfer_q;

endmodule
